adc128s_a2d_model: RTL and testbench

// - Behavioural, synthesizable SPI slave model of an 8-channel, 12-bit ADC128S-style A2D converter.
// - Sits on the A2D SPI bus of the Segway system bench and serves the controller's A2D interface.
// - Reports the left load cell, right load cell and battery levels, taken from bench-driven set inputs.
// - Each 16-bit frame returns the conversion of the channel addressed in the previous frame.

---
 rtl/adc128s_a2d_model_pkg.sv | 18 +
 rtl/adc128s_a2d_model_edge_sync.sv | 22 ++
 rtl/adc128s_a2d_model.sv | 127 ++++++++++++
 tb/tb_adc128s_a2d_model.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/adc128s_a2d_model_pkg.sv
// Shared constants and types for the ADC128S-style A2D SPI slave model.
package a2d_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned CNT_W   = 5;

  localparam logic [ADDR_W-1:0] CH_LFT_DFLT  = 3'd0;
  localparam logic [ADDR_W-1:0] CH_RGHT_DFLT = 3'd4;
  localparam logic [ADDR_W-1:0] CH_BATT_DFLT = 3'd5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } a2d_state_e;

endpackage

// File: rtl/adc128s_a2d_model_edge_sync.sv
// Double-flop synchroniser plus a third stage for rise/fall detection.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [2:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= {3{RST_VAL}};
    else     ff <= {ff[1:0], din};
  end

  assign rise_c = ff[1] & ~ff[2];
  assign fall_c = ~ff[1] & ff[2];

endmodule

// File: rtl/adc128s_a2d_model.sv
// SPI slave model of an 8-channel 12-bit A2D; each frame returns the channel addressed by the previous one.
module adc128s_a2d_model
  import a2d_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CH_LFT  = CH_LFT_DFLT,
  parameter logic [ADDR_W-1:0] CH_RGHT = CH_RGHT_DFLT,
  parameter logic [ADDR_W-1:0] CH_BATT = CH_BATT_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] batt_set,
  input  logic [DATA_W-1:0] lft_cell_set,
  input  logic [DATA_W-1:0] rght_cell_set
);

  a2d_state_e         state, next_state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] rx_shft, tx_shft;
  logic [ADDR_W-1:0]  addr;
  logic               seen_rise;
  logic [1:0]         mosi_ff;
  logic               mosi_sync;
  logic               ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic [DATA_W-1:0]  chan_val;
  logic               cnt_full;
  logic               miso_en, miso_bit;
  logic               unused_bits;

  spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (SS_n),
    .rise_c (ss_rise),
    .fall_c (ss_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (SCLK),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall)
  );

  // MOSI shares the SCLK sync depth so data and edge stay aligned
  always_ff @(posedge clk) begin
    if (rst) mosi_ff <= 2'b00;
    else     mosi_ff <= {mosi_ff[0], MOSI};
  end
  assign mosi_sync = mosi_ff[1];

  always_comb begin
    chan_val = '0;
    if (addr == CH_LFT)       chan_val = lft_cell_set;
    else if (addr == CH_RGHT) chan_val = rght_cell_set;
    else if (addr == CH_BATT) chan_val = batt_set;
  end

  assign cnt_full    = (bit_cnt == CNT_W'(FRAME_W));
  assign unused_bits = rx_shft[FRAME_W-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ss_fall) next_state = ACTIVE;
      ACTIVE:  if (ss_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    miso_en  = 1'b0;
    miso_bit = 1'b0;
    if (state == ACTIVE) begin
      miso_en  = 1'b1;
      miso_bit = tx_shft[FRAME_W-1];
    end
  end

  assign MISO = miso_en ? miso_bit : 1'bz;

  // Shift registers, bit counter and stored channel address
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      rx_shft   <= '0;
      tx_shft   <= '0;
      addr      <= '0;
      seen_rise <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_shft   <= {4'h0, chan_val};
            bit_cnt   <= '0;
            seen_rise <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            if (cnt_full) addr <= rx_shft[13:11];
          end else begin
            if (sclk_rise) begin
              rx_shft   <= {rx_shft[FRAME_W-2:0], cnt_full ? 1'b0 : mosi_sync};
              seen_rise <= 1'b1;
              if (!cnt_full) bit_cnt <= bit_cnt + CNT_W'(1);
            end
            // A fall before the first rise would discard the MSB
            if (sclk_fall && seen_rise)
              tx_shft <= {tx_shft[FRAME_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc128s_a2d_model.sv
// Directed bench for the A2D SPI slave model; MISO net has a pullup so high-Z reads as 1.
`timescale 1ns/1ps
module tb_adc128s_a2d_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        ss_n;
  logic        sclk;
  logic        mosi;
  wire         miso;
  logic [11:0] batt_set, lft_cell_set, rght_cell_set;

  int checks = 0;
  int errors = 0;

  pullup (miso);

  adc128s_a2d_model dut (
    .clk           (clk),
    .rst           (rst),
    .SS_n          (ss_n),
    .SCLK          (sclk),
    .MOSI          (mosi),
    .MISO          (miso),
    .batt_set      (batt_set),
    .lft_cell_set  (lft_cell_set),
    .rght_cell_set (rght_cell_set)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] CMD_CH0 = 16'h0000;
  localparam logic [15:0] CMD_CH2 = 16'h1000;
  localparam logic [15:0] CMD_CH4 = 16'h2000;
  localparam logic [15:0] CMD_CH5 = 16'h2800;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI frame: SCLK half period 16 clk; optionally change batt_set after rise chg_bit
  task automatic do_frame(input logic [15:0] cmd, input int rises, input int chg_bit,
                          input logic [11:0] chg_val, output logic [15:0] resp);
    resp = 16'h0000;
    @(negedge clk);
    ss_n = 1'b0;
    wait_clk(16);
    for (int i = 0; i < rises; i++) begin
      sclk = 1'b0;
      mosi = cmd[15-i];
      wait_clk(16);
      resp[15-i] = miso;
      sclk = 1'b1;
      if (i == chg_bit) batt_set = chg_val;
      wait_clk(16);
    end
    ss_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset();
    logic [15:0] r;
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b1; mosi = 1'b0;
    lft_cell_set = 12'h1A0; rght_cell_set = 12'h0C0; batt_set = 12'hD80;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    checks++;
    if (miso !== 1'b1) begin
      errors++;
      $display("FAIL reset_miso_z: got %b, required released (pulled 1)", miso);
    end
    do_frame(CMD_CH4, 16, -1, 12'h000, r);
    checks++;
    if (r !== 16'h01A0) begin
      errors++;
      $display("FAIL first_frame_ch0: got %h, required 01a0", r);
    end
  endtask

  task automatic test_channels();
    logic [15:0] r;
    logic [15:0] cmds [4];
    logic [15:0] exps [4];
    cmds = '{CMD_CH4, CMD_CH5, CMD_CH0, CMD_CH0};
    exps = '{16'h00C0, 16'h00C0, 16'h0D80, 16'h01A0};
    for (int i = 0; i < 4; i++) begin
      do_frame(cmds[i], 16, -1, 12'h000, r);
      checks++;
      if (r !== exps[i]) begin
        errors++;
        $display("FAIL channel_frame%0d: got %h, required %h", i, r, exps[i]);
      end
    end
    checks++;
    if (miso !== 1'b1) begin
      errors++;
      $display("FAIL idle_miso_z: got %b, required released (pulled 1)", miso);
    end
  endtask

  task automatic test_unused_channel();
    logic [15:0] r;
    do_frame(CMD_CH2, 16, -1, 12'h000, r);
    checks++;
    if (r !== 16'h01A0) begin
      errors++;
      $display("FAIL unused_prev: got %h, required 01a0", r);
    end
    do_frame(CMD_CH5, 16, -1, 12'h000, r);
    checks++;
    if (r !== 16'h0000) begin
      errors++;
      $display("FAIL unused_ch2: got %h, required 0000", r);
    end
  endtask

  task automatic test_abort();
    logic [15:0] r;
    do_frame(CMD_CH4, 16, -1, 12'h000, r);
    checks++;
    if (r !== 16'h0D80) begin
      errors++;
      $display("FAIL abort_setup: got %h, required 0d80", r);
    end
    do_frame(CMD_CH5, 7, -1, 12'h000, r);
    do_frame(CMD_CH0, 16, -1, 12'h000, r);
    checks++;
    if (r !== 16'h00C0) begin
      errors++;
      $display("FAIL abort_addr_kept: got %h, required 00c0", r);
    end
  endtask

  task automatic test_sample_point();
    logic [15:0] r;
    do_frame(CMD_CH5, 16, -1, 12'h000, r);
    checks++;
    if (r !== 16'h01A0) begin
      errors++;
      $display("FAIL sample_setup: got %h, required 01a0", r);
    end
    batt_set = 12'h800;
    do_frame(CMD_CH5, 16, 3, 12'hFFF, r);
    checks++;
    if (r !== 16'h0800) begin
      errors++;
      $display("FAIL sample_midframe: got %h, required 0800", r);
    end
    do_frame(CMD_CH0, 16, -1, 12'h000, r);
    checks++;
    if (r !== 16'h0FFF) begin
      errors++;
      $display("FAIL sample_next: got %h, required 0fff", r);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] r;
    do_frame(CMD_CH4, 16, -1, 12'h000, r);
    checks++;
    if (r !== 16'h01A0) begin
      errors++;
      $display("FAIL rstmid_setup: got %h, required 01a0", r);
    end
    @(negedge clk);
    ss_n = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b0;
      mosi = CMD_CH5[15-i];
      wait_clk(16);
      sclk = 1'b1;
      wait_clk(16);
    end
    checks++;
    if (miso !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_driven: got %b, required 0", miso);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (miso !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_miso_z: got %b, required released (pulled 1)", miso);
    end
    ss_n = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    do_frame(CMD_CH4, 16, -1, 12'h000, r);
    checks++;
    if (r !== 16'h01A0) begin
      errors++;
      $display("FAIL rstmid_next_ch0: got %h, required 01a0", r);
    end
  endtask

  initial begin
    test_reset();
    test_channels();
    test_unused_channel();
    test_abort();
    test_sample_point();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
